uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART Transmitter among NUM_REQ byte sources (decoder output, status, debug) using round-robin arbitration.
- Accepts one byte per valid/ready handshake and drives the Transmitter's tx_en / fifo_empty / tx_data inputs. It holds them stable until the frame-done pulse arrives.
- Inserts a configurable inter-frame gap counted in baud sticks.
- Has a watchdog that aborts a frame if the done pulse never arrives.

Parameters:
- SIZE_DATA, 8, bits per byte passed to the Transmitter.
- NUM_REQ, 4, number of requesters (2..8).
- GAP_TICKS, 16, stick pulses of idle line between frames; 0 means no gap.
- TIMEOUT_TICKS, 352, stick pulses allowed in SEND before abort (2 x 11-bit frame x 16 oversample).

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous active-high reset.
- i_stick  in  1  baud oversample tick from baud_generator, one cycle wide.
- i_req_valid  in  NUM_REQ  per-requester byte valid.
- i_req_data  in  NUM_REQ*SIZE_DATA  packed bytes; requester k occupies bits [k*SIZE_DATA +: SIZE_DATA].
- o_req_ready  out  NUM_REQ  one-hot accept strobe; a transfer occurs when valid & ready.
- o_tx_en  out  1  to Transmitter i_tx_en.
- o_fifo_empty  out  1  to Transmitter i_fifo_empty (0 = byte available).
- o_tx_data  out  SIZE_DATA  to Transmitter i_tx_data.
- i_tx_done  in  1  from Transmitter o_tx_done, one-cycle end-of-frame pulse.
- o_grant_id  out  $clog2(NUM_REQ)  index of the requester whose byte is in flight.
- o_busy  out  1  high in SEND or GAP.
- o_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (sync, i_rst=1 at a rising edge):
  - state=IDLE, rr_ptr=0, counters=0, data register=0.
  - Outputs: o_tx_en=0, o_fifo_empty=1, o_tx_data=0, o_grant_id=0, o_busy=0, o_err=0, o_req_ready=0.
  - Reset mid-frame abandons the frame with no o_err. Resetting the Transmitter is the system's responsibility.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - o_req_ready is combinational. It is one-hot at requester g, the first valid index scanning from rr_ptr upward with wrap-around; all zeros if no valid.
  - On the handshake edge: latch i_req_data[g] into the data register, latch g into o_grant_id, set rr_ptr=(g+1) mod NUM_REQ, and go to SEND.
  - Latency: handshake edge to o_tx_en=1 is one cycle.
- SEND:
  - o_tx_en=1, o_fifo_empty=0, o_tx_data=data register; all held constant. o_req_ready=0.
  - Count i_stick pulses.
  - If i_tx_done=1: go to GAP, or to IDLE when GAP_TICKS=0. o_tx_en=0 and o_fifo_empty=1 from the next cycle.
  - If the stick count reaches TIMEOUT_TICKS with no done: pulse o_err one cycle, go to GAP.
  - If done and timeout occur in the same cycle, done wins and there is no o_err.
- GAP: o_tx_en=0, o_fifo_empty=1. Count i_stick pulses; on the GAP_TICKS-th pulse go to IDLE.
- i_tx_done outside SEND is ignored.
- i_stick and i_tx_done in the same cycle: done takes priority; the stick is not counted.
- Requesters must hold valid and data until accepted. Valid must not depend on ready.
- A requester deasserting valid before acceptance is legal and loses its turn only for that cycle.
- Fairness: with all requesters valid, grants rotate 0,1,...,NUM_REQ-1,0.
- Widths: tick counter is $clog2(max(GAP_TICKS,TIMEOUT_TICKS)+1) bits, shared between SEND and GAP, and cleared on every state entry.

Decomposition:
- Package uart_pkg: state enum tx_arb_state_t {IDLE, SEND, GAP}, and default constants for SIZE_DATA, OVER_SAMPLE=16 and the frame-length-derived TIMEOUT_TICKS.
- One sub-module, rr_arbiter (combinational: req vector + ptr -> one-hot grant + index), reusable elsewhere.

Test Plan:
- Single request, requester 2 valid with 0x55 and NUM_REQ=4 -> o_req_ready=0100 for one cycle, then o_tx_en=1 and o_tx_data=0x55 the next cycle. Stays in SEND until i_tx_done, then GAP for 16 sticks, then IDLE.
- All four requesters valid with 0xA0..0xA3 -> serial Transmitter output shows bytes in order A0,A1,A2,A3,A0, and o_grant_id cycles 0..3.
- Requesters 1 and 3 valid with rr_ptr=2 -> requester 3 is granted first, then 1 (wrap-around).
- i_tx_done held low (Transmitter disabled) -> o_err pulses exactly once after 352 sticks. The arbiter then completes GAP and accepts the next request.
- Assert i_rst in the middle of a SEND -> next cycle o_tx_en=0, o_fifo_empty=1, o_busy=0, rr_ptr=0, no o_err.
- GAP_TICKS=0 with back-to-back valid -> handshake occurs the cycle after done, and the re-launch gap is 2 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART transmit-side blocks.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [1:0] {IDLE, SEND, GAP} tx_arb_state_t;

  localparam int SIZE_DATA_DEF     = 8;
  localparam int OVER_SAMPLE       = 16;
  localparam int FRAME_BITS        = 11;
  localparam int TIMEOUT_TICKS_DEF = 2 * FRAME_BITS * OVER_SAMPLE;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr,
// wrapping around, returned both one-hot and as an index.
`timescale 1ns/1ps
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  function automatic int wrap_idx(input logic [IW-1:0] p, input int i);
    return (int'(p) + i) % N;
  endfunction

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[wrap_idx(ptr, i)]) begin
        grant[wrap_idx(ptr, i)] = 1'b1;
        idx                     = IW'(wrap_idx(ptr, i));
        any                     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte sources,
// with an inter-frame gap and a done-pulse watchdog, both counted in sticks.
`timescale 1ns/1ps
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int SIZE_DATA     = SIZE_DATA_DEF,
  parameter int NUM_REQ       = 4,
  parameter int GAP_TICKS     = 16,
  parameter int TIMEOUT_TICKS = TIMEOUT_TICKS_DEF
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_stick,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ*SIZE_DATA-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]             o_req_ready,
  output logic                           o_tx_en,
  output logic                           o_fifo_empty,
  output logic [SIZE_DATA-1:0]           o_tx_data,
  input  logic                           i_tx_done,
  output logic [$clog2(NUM_REQ)-1:0]     o_grant_id,
  output logic                           o_busy,
  output logic                           o_err
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(max_int(GAP_TICKS, TIMEOUT_TICKS) + 1);
  // With no gap configured a finished or aborted frame returns straight to IDLE.
  localparam tx_arb_state_t POST_SEND = (GAP_TICKS == 0) ? IDLE : GAP;
  localparam logic          POST_BUSY = (GAP_TICKS != 0);

  tx_arb_state_t        state;
  logic [GW-1:0]        rr_ptr;
  logic [CW-1:0]        tick_cnt;
  logic [CW-1:0]        tick_next;
  logic [SIZE_DATA-1:0] data_q;
  logic [GW-1:0]        grant_q;
  logic                 tx_en_q;
  logic                 busy_q;
  logic                 err_q;

  logic [NUM_REQ-1:0]   arb_grant;
  logic [GW-1:0]        arb_idx;
  logic                 arb_any;
  logic [GW-1:0]        next_ptr;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (GW)
  ) u_rr_arbiter (
    .req   (i_req_valid),
    .ptr   (rr_ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign next_ptr     = (arb_idx == GW'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
  assign tick_next    = tick_cnt + 1'b1;
  assign o_req_ready  = (state == IDLE) ? arb_grant : '0;
  assign o_tx_en      = tx_en_q;
  assign o_fifo_empty = ~tx_en_q;
  assign o_tx_data    = data_q;
  assign o_grant_id   = grant_q;
  assign o_busy       = busy_q;
  assign o_err        = err_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      tick_cnt <= '0;
      data_q   <= '0;
      grant_q  <= '0;
      tx_en_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (arb_any) begin
            data_q   <= i_req_data[arb_idx*SIZE_DATA +: SIZE_DATA];
            grant_q  <= arb_idx;
            rr_ptr   <= next_ptr;
            tick_cnt <= '0;
            tx_en_q  <= 1'b1;
            busy_q   <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          // A done pulse beats both a coincident stick and a coincident timeout.
          if (i_tx_done) begin
            tick_cnt <= '0;
            tx_en_q  <= 1'b0;
            busy_q   <= POST_BUSY;
            state    <= POST_SEND;
          end else if (i_stick) begin
            if (tick_next == CW'(TIMEOUT_TICKS)) begin
              err_q    <= 1'b1;
              tick_cnt <= '0;
              tx_en_q  <= 1'b0;
              busy_q   <= POST_BUSY;
              state    <= POST_SEND;
            end else begin
              tick_cnt <= tick_next;
            end
          end
        end
        GAP: begin
          if (i_stick) begin
            if (tick_next == CW'(GAP_TICKS)) begin
              tick_cnt <= '0;
              busy_q   <= 1'b0;
              state    <= IDLE;
            end else begin
              tick_cnt <= tick_next;
            end
          end
        end
        default: begin
          state   <= IDLE;
          tx_en_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int GAPT = 16;
  localparam int TMO  = 352;
  localparam int P_IDLE = 0;
  localparam int P_SEND = 1;
  localparam int P_GAP  = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           stick = 1'b0;
  logic           done = 1'b0;
  logic [N-1:0]   valid = '0;
  logic [N*W-1:0] data = '0;
  logic [N-1:0]   ready;
  logic           tx_en, fifo_empty, busy, err;
  logic [W-1:0]   tx_data;
  logic [1:0]     gid;

  logic           ng_stick = 1'b0;
  logic           ng_done = 1'b0;
  logic [N-1:0]   ng_valid = '0;
  logic [N*W-1:0] ng_data = 32'hB3B2B1B0;
  logic [N-1:0]   ng_ready;
  logic           ng_tx_en, ng_fe, ng_busy, ng_err;
  logic [W-1:0]   ng_tx_data;
  logic [1:0]     ng_gid;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.SIZE_DATA(W), .NUM_REQ(N), .GAP_TICKS(GAPT), .TIMEOUT_TICKS(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_stick(stick), .i_req_valid(valid), .i_req_data(data),
    .o_req_ready(ready), .o_tx_en(tx_en), .o_fifo_empty(fifo_empty), .o_tx_data(tx_data),
    .i_tx_done(done), .o_grant_id(gid), .o_busy(busy), .o_err(err));

  uart_tx_arbiter #(.SIZE_DATA(W), .NUM_REQ(N), .GAP_TICKS(0), .TIMEOUT_TICKS(TMO)) dut_nogap (
    .i_clk(clk), .i_rst(rst), .i_stick(ng_stick), .i_req_valid(ng_valid), .i_req_data(ng_data),
    .o_req_ready(ng_ready), .o_tx_en(ng_tx_en), .o_fifo_empty(ng_fe), .o_tx_data(ng_tx_data),
    .i_tx_done(ng_done), .o_grant_id(ng_gid), .o_busy(ng_busy), .o_err(ng_err));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase, rotating pointer and stick count since phase entry.
  int           m_phase = P_IDLE;
  int           m_ptr = 0;
  int           m_cnt = 0;
  int           m_gid = 0;
  logic [W-1:0] m_data = '0;
  logic         m_err = 1'b0;
  logic [N-1:0] m_acc = '0;
  logic         chk_en = 1'b0;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int i = 0; i < N; i++)
      if (v[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = pick(valid, m_ptr);
    if (m_phase == P_IDLE && g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  always @(posedge clk) begin
    m_err <= 1'b0;
    m_acc <= '0;
    if (rst) begin
      m_phase <= P_IDLE; m_ptr <= 0; m_cnt <= 0; m_gid <= 0; m_data <= '0;
    end else if (m_phase == P_IDLE) begin
      if (pick(valid, m_ptr) >= 0) begin
        m_gid   <= pick(valid, m_ptr);
        m_data  <= data[pick(valid, m_ptr)*W +: W];
        m_ptr   <= (pick(valid, m_ptr) + 1) % N;
        m_acc[pick(valid, m_ptr)] <= 1'b1;
        m_phase <= P_SEND;
        m_cnt   <= 0;
      end
    end else if (m_phase == P_SEND) begin
      if (done) begin
        m_phase <= P_GAP; m_cnt <= 0;
      end else if (stick) begin
        if (m_cnt + 1 == TMO) begin
          m_err <= 1'b1; m_phase <= P_GAP; m_cnt <= 0;
        end else m_cnt <= m_cnt + 1;
      end
    end else if (stick) begin
      if (m_cnt + 1 == GAPT) begin
        m_phase <= P_IDLE; m_cnt <= 0;
      end else m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_ready", ready, exp_ready());
      chk("m_tx_en", tx_en, m_phase == P_SEND);
      chk("m_fifo_empty", fifo_empty, m_phase != P_SEND);
      chk("m_tx_data", tx_data, m_data);
      chk("m_grant_id", gid, m_gid);
      chk("m_busy", busy, m_phase != P_IDLE);
      chk("m_err", err, m_err);
    end
  end

  task automatic step(input logic s, input logic d);
    @(posedge clk); #1;
    stick = s;
    done  = d;
  endtask

  task automatic sticks(input int n);
    repeat (n) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic send_done();
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "global timeout");
  end

  initial begin
    int send_age;
    int target;
    int tmo_left;
    bit was_send;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_fifo_empty", fifo_empty, 1);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_grant_id", gid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", ready, 0);
    chk_en = 1'b1;

    // Single request from requester 2
    @(posedge clk); #1;
    valid = 4'b0100; data[2*W +: W] = 8'h55;
    @(negedge clk); chk("single_ready", ready, 4'b0100);
    @(posedge clk); #1 valid = '0;
    @(negedge clk);
    chk("single_tx_en", tx_en, 1); chk("single_data", tx_data, 8'h55);
    chk("single_gid", gid, 2); chk("single_ready_send", ready, 0);
    sticks(10);
    send_done();
    @(negedge clk);
    chk("done_tx_en", tx_en, 0); chk("done_fifo_empty", fifo_empty, 1); chk("done_busy", busy, 1);
    sticks(15);
    @(negedge clk); chk("gap15_busy", busy, 1);
    sticks(1);
    @(negedge clk); chk("gap16_busy", busy, 0);

    // Move pointer to 2 by granting requester 1, then wrap-around 3 before 1
    valid = 4'b0010; data[1*W +: W] = 8'h11; data[3*W +: W] = 8'h33;
    @(posedge clk); #1 valid = '0;
    send_done(); sticks(GAPT);
    valid = 4'b1010;
    @(negedge clk); chk("wrap_ready3", ready, 4'b1000);
    @(posedge clk); #1 valid = 4'b0010;
    @(negedge clk); chk("wrap_gid3", gid, 3); chk("wrap_data3", tx_data, 8'h33);
    send_done(); sticks(GAPT);
    @(negedge clk); chk("wrap_ready1", ready, 4'b0010);
    @(posedge clk); #1 valid = '0;
    @(negedge clk); chk("wrap_gid1", gid, 1); chk("wrap_data1", tx_data, 8'h11);
    send_done(); sticks(GAPT);

    // Fairness with all requesters valid after a fresh reset
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    valid = 4'b1111; data = 32'hA3A2A1A0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rr_gid", gid, i % 4);
      chk("rr_data", tx_data, 8'hA0 + (i % 4));
      #1;
      if (i == 4) valid = '0;
      send_done(); sticks(GAPT);
    end

    // Done and timeout on the same stick: done wins
    valid = 4'b0100; data[2*W +: W] = 8'h77;
    @(posedge clk); #1 valid = '0;
    sticks(TMO - 1);
    step(1'b1, 1'b1); step(1'b0, 1'b0);
    @(negedge clk);
    chk("tie_err", err, 0); chk("tie_tx_en", tx_en, 0); chk("tie_busy", busy, 1);
    sticks(GAPT);

    // Watchdog abort after TMO sticks with no done
    valid = 4'b0100; data[2*W +: W] = 8'h5A;
    @(posedge clk); #1 valid = '0;
    sticks(TMO - 1);
    @(negedge clk); chk("tmo_err_early", err, 0); chk("tmo_tx_en_early", tx_en, 1);
    sticks(1);
    @(negedge clk); chk("tmo_err", err, 1); chk("tmo_tx_en", tx_en, 0); chk("tmo_busy", busy, 1);
    step(1'b0, 1'b0);
    @(negedge clk); chk("tmo_err_once", err, 0);
    sticks(GAPT);
    @(negedge clk); chk("tmo_gap_busy", busy, 0);
    valid = 4'b0001; data[0 +: W] = 8'hC0;
    @(posedge clk); #1 valid = '0;
    @(negedge clk); chk("tmo_next_tx_en", tx_en, 1); chk("tmo_next_gid", gid, 0);
    send_done(); sticks(GAPT);

    // Reset in the middle of a SEND
    valid = 4'b0010;
    @(posedge clk); #1 valid = '0;
    sticks(5);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx_en", tx_en, 0); chk("mid_rst_fe", fifo_empty, 1);
    chk("mid_rst_busy", busy, 0); chk("mid_rst_err", err, 0);
    valid = 4'b0011;
    #1 chk("mid_rst_ptr0", ready, 4'b0001);
    @(posedge clk); #1 valid = '0;
    @(negedge clk); chk("mid_rst_gid", gid, 0);
    send_done(); sticks(GAPT);

    // No-gap instance: relaunch two cycles after done
    @(posedge clk); #1 ng_valid = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    chk("ng_tx_en0", ng_tx_en, 1); chk("ng_gid0", ng_gid, 0); chk("ng_data0", ng_tx_data, 8'hB0);
    @(posedge clk); #1 ng_done = 1'b1;
    @(posedge clk); #1 ng_done = 1'b0;
    @(negedge clk);
    chk("ng_idle_tx_en", ng_tx_en, 0); chk("ng_idle_fe", ng_fe, 1);
    chk("ng_idle_ready", ng_ready, 4'b0010); chk("ng_idle_busy", ng_busy, 0);
    @(posedge clk);
    @(negedge clk);
    chk("ng_tx_en1", ng_tx_en, 1); chk("ng_gid1", ng_gid, 1); chk("ng_data1", ng_tx_data, 8'hB1);
    chk("ng_err", ng_err, 0);
    @(posedge clk); #1 ng_valid = '0; ng_done = 1'b1;
    @(posedge clk); #1 ng_done = 1'b0;

    // Randomized traffic against the model
    was_send = 1'b0; send_age = 0; target = 1; tmo_left = 3;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < N; k++) begin
        if (m_acc[k]) data[k*W +: W] = W'($urandom);
        valid[k] = ($urandom_range(0, 3) != 0);
      end
      stick = 1'($urandom_range(0, 1));
      if (m_phase == P_SEND) begin
        if (!was_send) begin
          send_age = 0;
          if (tmo_left > 0 && $urandom_range(0, 5) == 0) begin
            target = -1; tmo_left--;
          end else target = $urandom_range(1, 30);
        end
        send_age++;
        done = (send_age == target);
        was_send = 1'b1;
      end else begin
        done = ($urandom_range(0, 15) == 0);
        was_send = 1'b0;
      end
    end
    @(posedge clk); #1;
    valid = '0; done = 1'b0; stick = 1'b0;
    @(negedge clk);
    chk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
